// File: rtl/pipeline_reg_memwb_multi_pkg.sv
// Shared definitions for the multi-lane MEM/WB pipeline register.
package pipeline_reg_memwb_multi_pkg;

  localparam int unsigned COMMON_WIDTH = 32;
  localparam int unsigned REG_NUM      = 5;

  // Skid buffer fill state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } memwb_state_e;

endpackage

// File: rtl/pipeline_reg_memwb_multi_lane_cond.sv
// Per-lane writeback conditioning: result select and register-zero suppression.
module memwb_lane_cond
  import pipeline_reg_memwb_multi_pkg::*;
#(
  parameter int unsigned DATA_W = COMMON_WIDTH,
  parameter int unsigned RA_W   = REG_NUM
) (
  input  logic [RA_W-1:0]   rd,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic              sel_alu,
  output logic [DATA_W-1:0] data_c,
  output logic              we_c
);

  // Data for rd=0 still passes through; only its enable is dropped.
  assign data_c = sel_alu ? alu : mem;
  assign we_c   = (rd != '0);

endmodule

// File: rtl/pipeline_reg_memwb_multi.sv
// MEM/WB stage: conditions a multi-lane writeback bundle and holds it in a
// two-entry skid buffer behind a valid/ready handshake. MAIN drives the
// outputs and is also the forwarding source for earlier stages.
module pipeline_reg_memwb_multi
  import pipeline_reg_memwb_multi_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = COMMON_WIDTH,
  parameter int unsigned RA_W   = REG_NUM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*RA_W-1:0]   in_rd,
  input  logic [LANES*DATA_W-1:0] in_alu,
  input  logic [LANES*DATA_W-1:0] in_mem,
  input  logic [LANES-1:0]        in_sel_alu,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_we,
  output logic [LANES*RA_W-1:0]   out_rd,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy
);

  localparam int unsigned RD_W = LANES * RA_W;
  localparam int unsigned D_W  = LANES * DATA_W;

  memwb_state_e      state, state_d;
  logic [LANES-1:0]  main_we, main_we_d, skid_we, skid_we_d;
  logic [RD_W-1:0]   main_rd, main_rd_d, skid_rd, skid_rd_d;
  logic [D_W-1:0]    main_data, main_data_d, skid_data, skid_data_d;

  logic [D_W-1:0]    cond_data_c;
  logic [LANES-1:0]  lane_we_c;
  logic [LANES-1:0]  cond_we_c;
  logic              push_c;
  logic              pop_c;

  // One conditioning slice per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    memwb_lane_cond #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W)
    ) u_cond (
      .rd      (in_rd[g*RA_W +: RA_W]),
      .alu     (in_alu[g*DATA_W +: DATA_W]),
      .mem     (in_mem[g*DATA_W +: DATA_W]),
      .sel_alu (in_sel_alu[g]),
      .data_c  (cond_data_c[g*DATA_W +: DATA_W]),
      .we_c    (lane_we_c[g])
    );
  end

  // Same-destination collision: a younger (higher) lane kills older writes.
  always_comb begin
    cond_we_c = lane_we_c;
    for (int i = 0; i < int'(LANES); i++) begin
      for (int j = i + 1; j < int'(LANES); j++) begin
        if (lane_we_c[j] && (in_rd[i*RA_W +: RA_W] == in_rd[j*RA_W +: RA_W])) begin
          cond_we_c[i] = 1'b0;
        end
      end
    end
  end

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;
  assign out_we    = out_valid ? main_we : '0;
  assign out_rd    = main_rd;
  assign out_data  = main_data;
  assign occupancy = 2'(state);

  // Skid FSM next state and entry updates; flush overrides everything.
  always_comb begin
    state_d     = state;
    main_we_d   = main_we;
    main_rd_d   = main_rd;
    main_data_d = main_data;
    skid_we_d   = skid_we;
    skid_rd_d   = skid_rd;
    skid_data_d = skid_data;

    if (flush) begin
      state_d   = ST_EMPTY;
      main_we_d = '0;
      skid_we_d = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push_c) begin
            state_d     = ST_ONE;
            main_we_d   = cond_we_c;
            main_rd_d   = in_rd;
            main_data_d = cond_data_c;
          end
        end
        ST_ONE: begin
          if (push_c && !pop_c) begin
            state_d     = ST_TWO;
            skid_we_d   = cond_we_c;
            skid_rd_d   = in_rd;
            skid_data_d = cond_data_c;
          end else if (!push_c && pop_c) begin
            state_d = ST_EMPTY;
          end else if (push_c && pop_c) begin
            main_we_d   = cond_we_c;
            main_rd_d   = in_rd;
            main_data_d = cond_data_c;
          end
        end
        ST_TWO: begin
          if (pop_c) begin
            state_d     = ST_ONE;
            main_we_d   = skid_we;
            main_rd_d   = skid_rd;
            main_data_d = skid_data;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; reset discards any held bundles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_we   <= '0;
      main_rd   <= '0;
      main_data <= '0;
      skid_we   <= '0;
      skid_rd   <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_d;
      main_we   <= main_we_d;
      main_rd   <= main_rd_d;
      main_data <= main_data_d;
      skid_we   <= skid_we_d;
      skid_rd   <= skid_rd_d;
      skid_data <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipeline_reg_memwb_multi.sv
// Self-checking bench for pipeline_reg_memwb_multi (LANES=2, DATA_W=32, RA_W=5).
module tb_pipeline_reg_memwb_multi;

  localparam int unsigned LANES  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RA_W   = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*RA_W-1:0]   in_rd;
  logic [LANES*DATA_W-1:0] in_alu;
  logic [LANES*DATA_W-1:0] in_mem;
  logic [LANES-1:0]        in_sel_alu;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_we;
  logic [LANES*RA_W-1:0]   out_rd;
  logic [LANES*DATA_W-1:0] out_data;
  logic [1:0]              occupancy;

  pipeline_reg_memwb_multi #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_alu     (in_alu),
    .in_mem     (in_mem),
    .in_sel_alu (in_sel_alu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_we     (out_we),
    .out_rd     (out_rd),
    .out_data   (out_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  we;
    logic [9:0]  rd;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  rd0, rd1;
    logic [31:0] alu0, alu1, mem0, mem1;
    logic [1:0]  sel;
    logic [1:0]  exp_we;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  vec_t vecs[6];
  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conditioning for two lanes: lane 1 is younger and always wins.
  function automatic ent_t model(input logic [9:0] rd, input logic [63:0] alu,
                                 input logic [63:0] mem, input logic [1:0] sel);
    ent_t e;
    logic [4:0] r0, r1;
    r0 = rd[4:0];
    r1 = rd[9:5];
    e.rd            = rd;
    e.data[31:0]    = sel[0] ? alu[31:0]  : mem[31:0];
    e.data[63:32]   = sel[1] ? alu[63:32] : mem[63:32];
    e.we[1]         = (r1 != 5'd0);
    e.we[0]         = (r0 != 5'd0) && (r0 != r1);
    return e;
  endfunction

  task automatic set_in(input logic [4:0] rd0, input logic [4:0] rd1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] m0, input logic [31:0] m1,
                        input logic [1:0] sel);
    in_rd      = {rd1, rd0};
    in_alu     = {a1, a0};
    in_mem     = {m1, m0};
    in_sel_alu = sel;
  endtask

  // One clock: probe in_ready against out_ready, score pop/push, then advance.
  task automatic step();
    logic o;
    ent_t e;
    @(negedge clk);
    o = out_ready;
    out_ready = ~o;
    #1;
    check("in_ready_vs_state", {63'd0, in_ready}, {63'd0, (occupancy != 2'd2)});
    out_ready = o;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pop: unexpected bundle rd=%h data=%h, none expected", out_rd, out_data);
      end else begin
        e = sb.pop_front();
        check("sb_we",   {62'd0, out_we}, {62'd0, e.we});
        check("sb_rd",   {54'd0, out_rd}, {54'd0, e.rd});
        check("sb_data", out_data, e.data);
      end
    end
    if (!out_valid) check("we_idle", {62'd0, out_we}, 64'd0);
    if (in_valid && in_ready) sb.push_back(model(in_rd, in_alu, in_mem, in_sel_alu));
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  int sent;
  int cycles;

  initial begin
    vecs[0] = '{5'd3,  5'd7, 32'h11,       32'h22, 32'hA,  32'hB,        2'b01, 2'b11, 32'h11,       32'hB};
    vecs[1] = '{5'd0,  5'd5, 32'h1,        32'h2,  32'h3,  32'h4,        2'b11, 2'b10, 32'h1,        32'h2};
    vecs[2] = '{5'd9,  5'd9, 32'h1,        32'h2,  32'h0,  32'h0,        2'b11, 2'b10, 32'h1,        32'h2};
    vecs[3] = '{5'd0,  5'd0, 32'h5,        32'h6,  32'h7,  32'h8,        2'b00, 2'b00, 32'h7,        32'h8};
    vecs[4] = '{5'd31, 5'd1, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hDEADBEEF, 2'b01, 2'b11, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[5] = '{5'd4,  5'd4, 32'h10,       32'h20, 32'h30, 32'h40,       2'b10, 2'b10, 32'h30,       32'h20};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_we",    {62'd0, out_we},    64'd0);
    check("rst_out_rd",    {54'd0, out_rd},    64'd0);
    check("rst_out_data",  out_data,           64'd0);
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Table vectors: single push with out_ready high, one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].rd0, vecs[i].rd1, vecs[i].alu0, vecs[i].alu1,
             vecs[i].mem0, vecs[i].mem1, vecs[i].sel);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("vec_out_valid", {63'd0, out_valid}, 64'd1);
      check("vec_out_we",    {62'd0, out_we}, {62'd0, vecs[i].exp_we});
      check("vec_out_rd",    {54'd0, out_rd}, {54'd0, vecs[i].rd1, vecs[i].rd0});
      check("vec_out_data",  out_data, {vecs[i].exp_d1, vecs[i].exp_d0});
      step();
      check("vec_drained",   {63'd0, out_valid}, 64'd0);
      check("vec_occ0",      {62'd0, occupancy}, 64'd0);
    end

    // Backpressure fills both entries; release drains in order.
    out_ready = 1'b0;
    set_in(5'd1, 5'd2, 32'h100, 32'h200, 32'h0, 32'h0, 2'b11);
    in_valid = 1'b1;
    step();
    set_in(5'd6, 5'd6, 32'h0, 32'h0, 32'h300, 32'h400, 2'b00);
    step();
    in_valid = 1'b0;
    check("bp_occ2",     {62'd0, occupancy}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready},  64'd0);
    check("bp_hold_b0",  out_data, {32'h200, 32'h100});
    step();
    check("bp_still_b0", out_data, {32'h200, 32'h100});
    check("bp_still_we", {62'd0, out_we}, 64'd3);
    out_ready = 1'b1;
    step();
    check("bp_occ1",  {62'd0, occupancy}, 64'd1);
    check("bp_b1",    out_data, {32'h400, 32'h300});
    check("bp_b1_we", {62'd0, out_we}, 64'd2);
    step();
    check("bp_occ0",  {62'd0, occupancy}, 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush in TWO with a push offered and a pop completing.
    out_ready = 1'b0;
    set_in(5'd2, 5'd3, 32'hA1, 32'hA2, 32'h0, 32'h0, 2'b11);
    in_valid = 1'b1;
    step();
    set_in(5'd4, 5'd5, 32'hB1, 32'hB2, 32'h0, 32'h0, 2'b11);
    step();
    check("fl_occ2", {62'd0, occupancy}, 64'd2);
    set_in(5'd8, 5'd9, 32'hC1, 32'hC2, 32'h0, 32'h0, 2'b11);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_occ0",      {62'd0, occupancy}, 64'd0);
    check("fl_we0",       {62'd0, out_we},    64'd0);
    step();
    check("fl_absent",    {63'd0, out_valid}, 64'd0);

    // Flush in ONE discards the concurrent push.
    out_ready = 1'b0;
    set_in(5'd10, 5'd11, 32'hD1, 32'hD2, 32'h0, 32'h0, 2'b11);
    in_valid = 1'b1;
    step();
    set_in(5'd12, 5'd13, 32'hE1, 32'hE2, 32'h0, 32'h0, 2'b11);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_occ0",  {62'd0, occupancy}, 64'd0);
    check("fl1_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while holding two bundles.
    set_in(5'd14, 5'd15, 32'hF1, 32'hF2, 32'h0, 32'h0, 2'b11);
    in_valid = 1'b1;
    step();
    set_in(5'd16, 5'd17, 32'hF3, 32'hF4, 32'h0, 32'h0, 2'b11);
    step();
    in_valid = 1'b0;
    check("ar_occ2", {62'd0, occupancy}, 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", {63'd0, out_valid}, 64'd0);
    check("ar_out_data",  out_data,           64'd0);
    check("ar_out_we",    {62'd0, out_we},    64'd0);
    check("ar_occ0",      {62'd0, occupancy}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ar_in_ready", {63'd0, in_ready}, 64'd1);

    // Random streaming against the scoreboard.
    sent   = 0;
    cycles = 0;
    while (sent < 100 && cycles < 3000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) sent++;
      step();
      cycles++;
    end
    check("stream_sent", 64'(sent), 64'd100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (occupancy != 2'd0) step();
    end
    check("stream_occ0",     {62'd0, occupancy}, 64'd0);
    check("stream_sb_empty", 64'(sb.size()),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
